// File: rtl/uart_tx_sched_if.sv
// Requester-side bundle of the shared UART transmitter: byte requests in, grant/status and serial line out.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      cur_id;
  logic                 busy;
  logic                 frame_done;
  logic                 tx_serial;

  modport master (
    output req, req_data,
    input  grant, cur_id, busy, frame_done, tx_serial
  );

  modport slave (
    input  req, req_data,
    output grant, cur_id, busy, frame_done, tx_serial
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter + 8N1 serializer sharing one UART line; grant one cycle after req in IDLE.
// Requests hold their level until granted; one frame in flight, bits advance only on baud_tick.
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int STOP_BITS = 1
) (
  input  logic            sched_clk,
  input  logic            sched_rst,
  input  logic            baud_tick,
  uart_tx_sched_if.slave  bus
);
  localparam int   ID_W      = $clog2(NUM_REQ);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [ID_W-1:0]   rr_ptr;
  logic              stop_hi;
  logic              stop_cnt;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic [NUM_REQ-1:0] pick_oh;
  logic [7:0]        pick_dat;
  int                idx;

  // Scan from farthest to nearest after rr_ptr so the nearest requester is the last write.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    pick_oh  = '0;
    pick_dat = '0;
    idx      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx > NUM_REQ - 1) begin
        idx = idx - NUM_REQ;
      end
      if (bus.req[idx[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = idx[ID_W-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_oh[i] = pick_vld && (pick_id == ID_W'(i));
      pick_dat   = pick_dat | ({8{pick_oh[i]}} & bus.req_data[8*i +: 8]);
    end
  end

  always_ff @(posedge sched_clk) begin
    if (sched_rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift          <= '0;
      rr_ptr         <= ID_W'(NUM_REQ - 1);
      stop_hi        <= 1'b0;
      stop_cnt       <= 1'b0;
      bus.grant      <= '0;
      bus.cur_id     <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.tx_serial  <= 1'b1;
    end else begin
      bus.grant      <= '0;
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            bus.grant  <= pick_oh;
            shift      <= pick_dat;
            bus.cur_id <= pick_id;
            rr_ptr     <= pick_id;
            bus.busy   <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            bus.tx_serial <= 1'b0;
            bit_cnt       <= '0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            bus.tx_serial <= shift[bit_cnt];
            bit_cnt       <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              stop_hi  <= 1'b0;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
        end
        STOP: begin
          // First tick raises the line; the following STOP_BITS ticks time its length.
          if (baud_tick) begin
            if (!stop_hi) begin
              bus.tx_serial <= 1'b1;
              stop_hi       <= 1'b1;
            end else if (stop_cnt == STOP_LAST) begin
              bus.busy       <= 1'b0;
              bus.frame_done <= 1'b1;
              state          <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: frame-level reference model checked every cycle, directed vector table and corner sequences.
module tb_uart_tx_sched;
  localparam int NR = 4;
  localparam int SB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_v, tick_v;
  logic [NR-1:0]   req_v;
  logic [8*NR-1:0] dat_v;
  logic            tick2;
  logic [1:0]      req2;
  logic [15:0]     dat2;

  uart_tx_sched_if #(.NUM_REQ(NR)) bus1();
  uart_tx_sched_if #(.NUM_REQ(2))  bus2();

  assign bus1.req      = req_v;
  assign bus1.req_data = dat_v;
  assign bus2.req      = req2;
  assign bus2.req_data = dat2;

  uart_tx_sched #(.NUM_REQ(NR), .STOP_BITS(SB)) u_dut (
    .sched_clk(clk), .sched_rst(rst_v), .baud_tick(tick_v), .bus(bus1));

  uart_tx_sched #(.NUM_REQ(2), .STOP_BITS(2)) u_dut2 (
    .sched_clk(clk), .sched_rst(rst_v), .baud_tick(tick2), .bus(bus2));

  int checks = 0;
  int errors = 0;

  // Reference model: frame progress is the number of ticks seen since the grant.
  bit            m_busy;
  int            m_n, m_ptr;
  logic [7:0]    m_byte;
  logic [NR-1:0] m_grant;
  logic [1:0]    m_id;
  logic          m_done, m_tx;

  int         per, tcnt, gcount;
  logic [1:0] gid;
  bit         rand_mode, cap_on;
  logic [9:0] line_cap;

  typedef struct {
    logic [NR-1:0] mask;
    logic [31:0]   bytes;
    int            per;
    logic [7:0]    order;
    int            n;
    logic [9:0]    line;
  } vec_t;
  vec_t vt[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_update();
    bit found;
    int sel;
    m_grant = '0;
    m_done  = 1'b0;
    if (rst_v) begin
      m_busy = 1'b0; m_n = 0; m_ptr = NR - 1; m_id = '0; m_tx = 1'b1;
    end else if (!m_busy) begin
      found = 1'b0; sel = 0;
      for (int k = 1; k <= NR; k++) begin
        if (!found && req_v[(m_ptr + k) % NR]) begin
          found = 1'b1;
          sel   = (m_ptr + k) % NR;
        end
      end
      if (found) begin
        m_grant[sel] = 1'b1;
        m_byte = dat_v[8*sel +: 8];
        m_id   = 2'(sel);
        m_ptr  = sel;
        m_busy = 1'b1;
        m_n    = 0;
      end
    end else if (tick_v) begin
      m_n++;
      if (m_n == 10 + SB) begin
        m_busy = 1'b0; m_done = 1'b1; m_tx = 1'b1;
      end else if (m_n == 1) begin
        m_tx = 1'b0;
      end else if (m_n <= 9) begin
        m_tx = m_byte[m_n-2];
      end else begin
        m_tx = 1'b1;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("cycle", 64'({bus1.grant, bus1.cur_id, bus1.busy, bus1.frame_done, bus1.tx_serial}),
          64'({m_grant, m_id, m_busy, m_done, m_tx}));
    if (cap_on && tick_v && m_busy && m_n >= 1 && m_n <= 10) line_cap[m_n-1] = bus1.tx_serial;
    if (m_done) cap_on = 1'b0;
    if (|bus1.grant) begin
      gcount++;
      gid = bus1.cur_id;
    end
  endtask

  task automatic cyc();
    if (per > 0) begin
      tick_v = (tcnt == per - 1);
      tcnt   = (tcnt == per - 1) ? 0 : tcnt + 1;
    end else if (per < 0) begin
      tick_v = ($urandom_range(0, 2) == 0);
    end
    step();
    for (int i = 0; i < NR; i++) begin
      if (m_grant[i]) begin
        if (rand_mode && $urandom_range(0, 3) == 0) dat_v[8*i +: 8] = 8'($urandom);
        else req_v[i] = 1'b0;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_v[i] && $urandom_range(0, 9) == 0) begin
          req_v[i] = 1'b1;
          dat_v[8*i +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic wait_grant(input int exp_id, input string nm);
    int c;
    c = 0;
    gcount = 0;
    while (gcount == 0 && c < 1000) begin
      cyc();
      c++;
    end
    check(nm, (gcount == 0) ? 64'd99 : 64'(gid), 64'(exp_id));
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (m_busy && c < 3000) begin
      cyc();
      c++;
    end
    check(nm, 64'(bus1.busy), 64'd0);
  endtask

  initial begin
    logic [7:0] ord;
    int dcount;
    rst_v = 1'b1; tick_v = 1'b0; req_v = '0; dat_v = '0;
    tick2 = 1'b0; req2 = '0; dat2 = '0;
    per = 0; tcnt = 0; rand_mode = 1'b0; cap_on = 1'b0; gcount = 0; gid = '0; line_cap = '0;

    step();
    step();
    check("reset_state", 64'({bus1.grant, bus1.cur_id, bus1.busy, bus1.frame_done, bus1.tx_serial}),
          64'(9'b0000_00_0_0_1));
    rst_v = 1'b0;

    // Two stop bits, 0xFF: frame_done must land right after the 12th tick counted from the start bit.
    req2 = 2'b01; dat2 = 16'h00FF;
    step();
    check("sb2_grant", 64'({bus2.grant, bus2.busy}), 64'(3'b011));
    req2 = '0;
    for (int t = 1; t <= 12; t++) begin
      step(); step();
      tick2 = 1'b1;
      step();
      tick2 = 1'b0;
      if (t < 12) check($sformatf("sb2_tick%0d", t), 64'({bus2.busy, bus2.frame_done, bus2.tx_serial}),
                        64'({1'b1, 1'b0, (t != 1)}));
      else check("sb2_done", 64'({bus2.busy, bus2.frame_done, bus2.tx_serial}), 64'(3'b011));
    end
    step();
    check("sb2_done_pulse", 64'(bus2.frame_done), 64'd0);

    vt[0] = '{4'b1111, 32'h33221100, 3,  8'hE4, 4, 10'h200};
    vt[1] = '{4'b0100, 32'h00A50000, 16, 8'h02, 1, 10'h34A};
    vt[2] = '{4'b0011, 32'h00005AC3, 2,  8'h04, 2, 10'h386};
    vt[3] = '{4'b1000, 32'h3C000000, 1,  8'h03, 1, 10'h278};
    vt[4] = '{4'b1010, 32'h81007E00, 5,  8'h0D, 2, 10'h2FC};
    for (int v = 0; v < 5; v++) begin
      req_v = vt[v].mask; dat_v = vt[v].bytes; per = vt[v].per; tcnt = 0;
      cap_on = 1'b1; line_cap = '0; gcount = 0; ord = vt[v].order;
      for (int c = 0; c < 3000 && !(gcount >= vt[v].n && !m_busy && req_v == '0); c++) begin
        cyc();
        if (|bus1.grant && gcount <= vt[v].n)
          check($sformatf("v%0d_order%0d", v, gcount - 1), 64'(bus1.cur_id), 64'(ord[2*(gcount-1) +: 2]));
      end
      check($sformatf("v%0d_ngrants", v), 64'(gcount), 64'(vt[v].n));
      check($sformatf("v%0d_line", v), 64'(line_cap), 64'(vt[v].line));
    end

    // Tick in the grant cycle is ignored; start bit waits for the next tick.
    per = 0;
    req_v = 4'b0001; dat_v[7:0] = 8'h96; tick_v = 1'b1;
    cyc();
    check("h1_grant", 64'({bus1.grant, bus1.tx_serial}), 64'(5'b0001_1));
    tick_v = 1'b0;
    cyc(); cyc(); cyc();
    check("h1_no_start", 64'(bus1.tx_serial), 64'd1);
    tick_v = 1'b1;
    cyc();
    tick_v = 1'b0;
    check("h1_start", 64'(bus1.tx_serial), 64'd0);
    per = 3; tcnt = 0;
    wait_idle("h1_idle");

    // A late riser is served ahead of a requester that re-requests after its own frame.
    per = 2; tcnt = 0;
    req_v = 4'b0001; dat_v[7:0] = 8'h11;
    wait_grant(0, "h2_first");
    for (int c = 0; c < 6; c++) cyc();
    req_v = req_v | 4'b1001; dat_v[31:24] = 8'h33; dat_v[7:0] = 8'h44;
    wait_grant(3, "h2_late3");
    wait_grant(0, "h2_re0");
    wait_idle("h2_idle");

    // Reset while d3 is on the line.
    req_v = 4'b0010; dat_v[15:8] = 8'hB7;
    wait_grant(1, "h3_grant");
    for (int c = 0; c < 500 && m_n < 5; c++) cyc();
    rst_v = 1'b1; req_v = '0;
    cyc();
    rst_v = 1'b0;
    check("h3_rst", 64'({bus1.grant, bus1.busy, bus1.frame_done, bus1.tx_serial}), 64'(7'b0000_001));
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (bus1.frame_done) dcount++;
    end
    check("h3_no_done", 64'(dcount), 64'd0);
    req_v = 4'b0011;
    wait_grant(0, "h3_after_rst");
    req_v = '0;
    wait_idle("h3_idle");

    rand_mode = 1'b1; per = -1;
    for (int c = 0; c < 3000; c++) begin
      rst_v = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst_v = 1'b0; rand_mode = 1'b0; req_v = '0; per = 2;
    wait_idle("rand_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler and 8N1 serializer that shares one UART transmit line between NUM_REQ byte producers.
- Driven by a one-cycle baud_tick enable from the tick-output variant of the team's baud generator.
- Arbitrates, latches the granted byte, sequences start/data/stop bits on tick boundaries, and reports completion.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- ID_W, $clog2(NUM_REQ), width of cur_id (derived; do not override).

Ports:
- sched_clk  input  1  system clock; all logic on rising edge.
- sched_rst  input  1  synchronous reset, active-high.
- baud_tick  input  1  one-cycle enable, one pulse per bit period.
- req  input  NUM_REQ  per-requester send request; held until granted.
- req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i]; stable while req[i]=1.
- grant  output  NUM_REQ  one-hot, one-cycle pulse when that requester's byte is latched.
- cur_id  output  ID_W  index of the requester that owns the current or last frame.
- busy  output  1  high from the grant cycle until the frame ends.
- frame_done  output  1  one-cycle pulse on frame completion.
- tx_serial  output  1  UART line, idle high, LSB first.

Behaviour:
- Clock and reset: one clock, sched_clk. Reset sched_rst is synchronous and active-high.
- Reset values: tx_serial=1, grant=0, busy=0, frame_done=0, cur_id=0, state=IDLE, bit_cnt=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority).
- Reset mid-frame: frame is abandoned. tx_serial returns to 1 at the reset edge; no frame_done; no grant.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If req≠0 in cycle c, select the first set bit searching from rr_ptr+1 upward, wrapping NUM_REQ-1→0.
  - At the end of c: grant[i]<=1, shift<=req_data[i], cur_id<=i, rr_ptr<=i, busy<=1, state<=START.
  - grant is high in cycle c+1 only. baud_tick is ignored in IDLE.
  - If req=0: outputs hold; tx_serial stays 1.
- START: wait for baud_tick. On the tick edge: tx_serial<=0, bit_cnt<=0, state<=DATA.
- DATA:
  - On each baud_tick: tx_serial<=shift[bit_cnt], bit_cnt<=bit_cnt+1.
  - On the tick that drives bit 7: bit_cnt wraps to 0 and state<=STOP.
- STOP:
  - On the first tick: tx_serial<=1.
  - After STOP_BITS further ticks: state<=IDLE, busy<=0, frame_done<=1 for one cycle.
  - Net result: every line level is held exactly one tick period, and the stop level lasts STOP_BITS full periods.
- Frame length: with the start bit at tick k, d0 appears at k+1, d7 at k+8, stop at k+9. frame_done is asserted in the cycle after tick k+9+STOP_BITS.
- Between ticks: all state, tx_serial and bit_cnt hold.
- Handshake rules:
  - A requester must deassert req[i] in the cycle after seeing grant[i], unless it has a new byte ready.
  - A req still high on return to IDLE is treated as a new request.
  - req changes outside IDLE have no effect; no queuing beyond the req level.
- Latency:
  - req asserted in IDLE → grant at the next edge (1 cycle).
  - Next grant no earlier than the IDLE cycle following frame_done. grant never overlaps busy of a previous frame.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,…,NUM_REQ-1,0,…
- Simultaneous events:
  - baud_tick in the same cycle as a grant is ignored, because state is still IDLE in that cycle; START waits for the next tick.
  - baud_tick in consecutive cycles is legal: one bit per tick.
- Arithmetic: bit_cnt is 3 bits. The stop counter is 1 bit (STOP_BITS≤2). rr_ptr is ID_W bits; wrap uses explicit compare to NUM_REQ-1, not power-of-two overflow.

Test Plan:
- Reset mid-frame: assert sched_rst during DATA bit 3 → next edge tx_serial=1, busy=0, no frame_done; then req[0] → grant[0] first (rr_ptr reset to NUM_REQ-1).
- Single byte: NUM_REQ=4, req[2]=1, data 8'hA5, baud_tick every 16 cycles → grant=4'b0100 for 1 cycle, cur_id=2; line 0,1,0,1,0,0,1,0,1,1, each level 16 cycles; frame_done once; busy low afterwards.
- Round-robin: req=4'b1111 held, each requester drops req after its grant → grant order 0,1,2,3; four frames back to back, one IDLE cycle between frame_done and the next grant.
- Wrap and skip: rr_ptr=2, req=4'b0011 → grant[0] then grant[1]; req[3] rising mid-frame → served after the current frame, before a rerequesting 0.
- STOP_BITS=2: byte 8'hFF → stop level held 2 tick periods; frame_done exactly after tick k+11; busy high for the whole frame.
- Tick edge cases: baud_tick coincident with grant → start bit at the following tick. baud_tick every cycle → 10-cycle frame, correct bit order for 8'h3C.
